// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size and FSM state encodings for the memory access unit
package mem_access_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/lane_mux.sv
// lane_mux: little-endian lane extract/extend for loads and lane merge for stores
module lane_mux
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{addr, 3'b000} +: 8];
  assign h = addr[1] ? word[31:16] : word[15:0];
  assign load = size == SIZE_BYTE ? (uns ? {24'b0, b} : {{24{b[7]}}, b}) :
                size == SIZE_HALF ? (uns ? {16'b0, h} : {{16{h[15]}}, h}) : word;
  always_comb begin
    merged = wdata;
    if (size == SIZE_BYTE) begin
      merged = word;
      merged[{addr, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SIZE_HALF) begin
      merged = word;
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: datapath load/store initiator driving a word-addressed data memory
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WORDS     = 1024,
  parameter int DATA_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [DATA_SIZE-1:0]      req_wdata,
  output logic                      resp_valid,
  output logic [DATA_SIZE-1:0]      resp_rdata,
  output logic                      resp_error,
  output logic [$clog2(WORDS)-1:0]  mem_addr,
  output logic [DATA_SIZE-1:0]      mem_wdata,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  input  logic [DATA_SIZE-1:0]      mem_rdata
);
  localparam int AW = $clog2(WORDS);
  state_t state, state_nx;
  logic write_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [AW+1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q, rdata_q, load, merged;
  logic accept, err, unused_addr;
  assign accept = req_valid && req_ready;
  assign err = req_size == 2'd3 || (req_size == SIZE_HALF && req_addr[0]) ||
               (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
  assign unused_addr = ^req_addr[31:AW+2];
  lane_mux u_lane_mux (
    .word(rdata_q), .addr(addr_q[1:0]), .size(size_q), .uns(uns_q),
    .wdata(wdata_q), .load(load), .merged(merged)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // rdata_q holds the word read in READ for both load extraction and store merge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        err_q   <= err;
        size_q  <= req_size;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      if (state == READ) rdata_q <= mem_rdata;
    end
  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_error   = 1'b0;
    resp_rdata   = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = err ? RESP : (req_write && req_size == SIZE_WORD) ? WRITE : READ;
      end
      READ: begin
        mem_read_en = 1'b1;
        mem_addr    = addr_q[AW+1:2];
        state_nx    = write_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        mem_addr     = addr_q[AW+1:2];
        mem_wdata    = merged;
        state_nx     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (write_q || err_q) ? '0 : load;
        state_nx   = IDLE;
      end
    endcase
  end
endmodule
